// File: rtl/baccarat_fsm.sv
// Baccarat game sequencer. This block deals one hand by pulsing one card-load
// enable per slow_clock cycle. It applies the third-card rules to the scores
// and drives the win lights. Only reset restarts the hand.
module baccarat_fsm (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic [3:0] state_out
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_P1    = 4'd1;
  localparam logic [3:0] S_D1    = 4'd2;
  localparam logic [3:0] S_P2    = 4'd3;
  localparam logic [3:0] S_D2    = 4'd4;
  localparam logic [3:0] S_EVAL1 = 4'd5;
  localparam logic [3:0] S_P3    = 4'd6;
  localparam logic [3:0] S_EVAL2 = 4'd7;
  localparam logic [3:0] S_D3    = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic [3:0] state_q, state_d;
  logic [3:0] pv;
  logic       bank_draw;

  // State register. The reset is active high despite its name.
  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Banker third-card rule. Face cards and "no card" count as 0.
  // A dealer score above 7 (including the impossible 10-15) means stand.
  always_comb begin
    pv        = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
    bank_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
      4'd3:             bank_draw = (pv != 4'd8);
      4'd4:             bank_draw = (pv >= 4'd2) && (pv <= 4'd7);
      4'd5:             bank_draw = (pv >= 4'd4) && (pv <= 4'd7);
      4'd6:             bank_draw = (pv >= 4'd6) && (pv <= 4'd7);
      default:          bank_draw = 1'b0;
    endcase
  end

  // Next-state logic. Illegal encodings fall back to S_IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = S_P1;
      S_P1:    state_d = S_D1;
      S_D1:    state_d = S_P2;
      S_P2:    state_d = S_D2;
      S_D2:    state_d = S_EVAL1;
      S_EVAL1: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_d = S_DONE;
        else if (pscore <= 4'd5)              state_d = S_P3;
        else if (dscore <= 4'd5)              state_d = S_D3;
        else                                  state_d = S_DONE;
      end
      S_P3:    state_d = S_EVAL2;
      S_EVAL2: state_d = bank_draw ? S_D3 : S_DONE;
      S_D3:    state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode. The win lights also look at the live scores, but only in S_DONE.
  always_comb begin
    load_pcard1      = (state_q == S_P1);
    load_dcard1      = (state_q == S_D1);
    load_pcard2      = (state_q == S_P2);
    load_dcard2      = (state_q == S_D2);
    load_pcard3      = (state_q == S_P3);
    load_dcard3      = (state_q == S_D3);
    player_win_light = (state_q == S_DONE) && (pscore >= dscore);
    dealer_win_light = (state_q == S_DONE) && (dscore >= pscore);
    state_out        = state_q;
  end

endmodule

// File: tb/tb_baccarat_fsm.sv
// Directed bench for baccarat_fsm. The bench drives the scores directly in
// place of the datapath. Expected states, loads and lights are written out by hand.
module tb_baccarat_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic       lp1, lp2, lp3, ld1, ld2, ld3, pwl, dwl;
  logic [3:0] st;
  int         total = 0;
  int         bad   = 0;

  baccarat_fsm dut (
    .slow_clock(clk), .resetb(rst),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
    .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
    .player_win_light(pwl), .dealer_win_light(dwl), .state_out(st)
  );

  always #5 clk = ~clk;

  // Loads packed as {d3,d2,d1,p3,p2,p1}; lights as {player,dealer}.
  function automatic logic [5:0] loads();
    return {ld3, ld2, ld1, lp3, lp2, lp1};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int l, input int w);
    chk({tag, ".state"},  int'(st), s);
    chk({tag, ".loads"},  int'(loads()), l);
    chk({tag, ".lights"}, int'({pwl, dwl}), w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from an edge, then release it 1 time unit after an edge.
  task automatic restart();
    #2 rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
  endtask

  // After release, four load states and then S_EVAL1 on the fifth edge.
  task automatic to_eval1();
    repeat (5) step();
  endtask

  logic [3:0] dl [0:7];
  logic [3:0] dh [0:7];

  initial begin
    // draw range of v per dscore (lo>hi means never); dscore 3 handled separately
    dl = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd4, 4'd6, 4'd1};
    dh = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd7, 4'd7, 4'd7, 4'd0};

    // Reset is active with no clock edge yet.
    #1;
    chk_all("reset", 0, 0, 0);
    step();
    chk_all("reset_hold", 0, 0, 0);

    // Natural hand: player has 8 and dealer has 3, so the player wins.
    pscore = 4'd8; dscore = 4'd3;
    rst = 1'b0;
    step(); chk_all("nat.p1", 1, 6'h01, 0);
    step(); chk_all("nat.d1", 2, 6'h08, 0);
    step(); chk_all("nat.p2", 3, 6'h02, 0);
    step(); chk_all("nat.d2", 4, 6'h10, 0);
    step(); chk_all("nat.ev1", 5, 0, 0);
    step(); chk_all("nat.done", 9, 0, 2'b10);
    step(); chk_all("nat.hold", 9, 0, 2'b10);
    dscore = 4'd9; #1;
    chk("nat.dealer_wins", int'({pwl, dwl}), 2'b01);

    // Player stands on 6 and dealer draws on 4. The final 6-6 tie lights both.
    restart();
    pscore = 4'd6; dscore = 4'd4;
    to_eval1();
    chk("stand.ev1", int'(st), 5);
    step(); chk_all("stand.d3", 8, 6'h20, 0);
    dscore = 4'd6;
    step(); chk_all("stand.done", 9, 0, 2'b11);

    // Player stands on 7 and dealer stands on 6: straight to S_DONE.
    restart();
    pscore = 4'd7; dscore = 4'd6;
    to_eval1();
    step(); chk_all("both_stand", 9, 0, 2'b10);

    // Full hand in 9 edges: all six loads fire once each.
    restart();
    pscore = 4'd5; dscore = 4'd2; pcard3 = 4'd9;
    step(); chk_all("full.p1", 1, 6'h01, 0);
    step(); chk_all("full.d1", 2, 6'h08, 0);
    step(); chk_all("full.p2", 3, 6'h02, 0);
    step(); chk_all("full.d2", 4, 6'h10, 0);
    step(); chk_all("full.ev1", 5, 0, 0);
    step(); chk_all("full.p3", 6, 6'h04, 0);
    step(); chk_all("full.ev2", 7, 0, 0);
    step(); chk_all("full.d3", 8, 6'h20, 0);
    pscore = 4'd3; dscore = 4'd7;
    step(); chk_all("full.done", 9, 0, 2'b01);

    // Illegal encoding 12: all outputs go to 0, then the FSM passes through S_IDLE into S_P1.
    #2 force dut.state_q = 4'd12;
    #1 chk_all("illegal.now", 12, 0, 0);
    release dut.state_q;
    step(); chk_all("illegal.idle", 0, 0, 0);
    step(); chk_all("illegal.p1", 1, 6'h01, 0);

    // Async reset while in S_P2 drops load_pcard2 in the same cycle.
    restart();
    step(); step(); step();
    chk_all("rst.p2", 3, 6'h02, 0);
    #2 rst = 1'b1;
    #1 chk_all("rst.async", 0, 0, 0);
    step(); chk_all("rst.held", 0, 0, 0);
    rst = 1'b0;
    step(); chk_all("rst.restart", 1, 6'h01, 0);

    // Out-of-range scores: a score of 12 in S_EVAL1 is treated as a natural.
    restart();
    pscore = 4'd2; dscore = 4'd12;
    to_eval1();
    step(); chk("wide.ev1", int'(st), 9);

    // In S_EVAL2 an out-of-range dealer score of 10 means the dealer stands.
    restart();
    pscore = 4'd2; dscore = 4'd10; pcard3 = 4'd3;
    to_eval1(); step(); step();
    step(); chk("wide.ev2", int'(st), 9);

    // A pcard3 of 0 counts as v=0: dealer on 4 stands, dealer on 3 draws.
    restart();
    pscore = 4'd2; dscore = 4'd4; pcard3 = 4'd0;
    to_eval1(); step(); step();
    step(); chk("p3zero.d4", int'(st), 9);
    restart();
    pscore = 4'd2; dscore = 4'd3; pcard3 = 4'd0;
    to_eval1(); step(); step();
    step(); chk("p3zero.d3", int'(st), 8);

    // Spot checks from the banker table.
    restart(); pscore = 4'd2; dscore = 4'd6; pcard3 = 4'd7;
    to_eval1(); step(); step(); step(); chk("spot.6_7", int'(st), 8);
    restart(); pscore = 4'd2; dscore = 4'd6; pcard3 = 4'd12;
    to_eval1(); step(); step(); step(); chk("spot.6_12", int'(st), 9);
    restart(); pscore = 4'd2; dscore = 4'd3; pcard3 = 4'd8;
    to_eval1(); step(); step(); step(); chk("spot.3_8", int'(st), 9);
    restart(); pscore = 4'd2; dscore = 4'd3; pcard3 = 4'd13;
    to_eval1(); step(); step(); step(); chk("spot.3_13", int'(st), 8);

    // Sweep the banker table over every dscore 0-7 and pcard3 1-13.
    for (int d = 0; d < 8; d++) begin
      for (int c = 1; c <= 13; c++) begin
        int v;
        bit draw;
        v = (c >= 10) ? 0 : c;
        draw = (d == 3) ? (v != 8) : (v >= int'(dl[d]) && v <= int'(dh[d]));
        restart();
        pscore = 4'd2; dscore = 4'(d); pcard3 = 4'(c);
        to_eval1(); step(); step(); step();
        chk($sformatf("sweep.d%0d_c%0d", d, c), int'(st), draw ? 8 : 9);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
